digit_sequence_player: RTL and testbench
========================================

// Module: digit_sequence_player
// PURPOSE
//  Programmable successor to the fixed phone-number counter. Plays back a stored
//  sequence of digits, one per advance tick, from a writable table of up to
//  MAX_LEN entries. Supports run-time sequence length, up/down direction, and
//  loop or one-shot mode. Drives digit displays and dial-out logic.
// PARAMETERS
//  DIGIT_W  4   width of each stored digit
//  MAX_LEN  16  table depth (number of entries); must be >= 2
//  IDX_W    $clog2(MAX_LEN)  index width (derived; do not override)
// PORTS
//  clk       in   1        rising-edge clock
//  rst       in   1        asynchronous, active-high reset
//  wr_en     in   1        table write strobe
//  wr_addr   in   IDX_W    table write address
//  wr_data   in   DIGIT_W  table write data
//  last_idx  in   IDX_W    index of final entry (sequence length - 1); sampled on start
//  dir       in   1        0 = up (0..last), 1 = down (last..0); sampled on start
//  loop      in   1        1 = wrap and repeat, 0 = one-shot; sampled on start
//  start     in   1        begin or restart playback
//  stop      in   1        abort playback
//  tick      in   1        advance enable; one step per cycle where tick=1
//  index     out  IDX_W    current table index
//  digit     out  DIGIT_W  table[index]
//  valid     out  1        digit is a live sequence element
//  busy      out  1        state == RUN
//  done      out  1        one-cycle pulse after one-shot completes
// BEHAVIOUR
//  - Reset: index=0, valid=0, busy=0, done=0, state=IDLE, all table entries=0.
//    digit therefore reads 0.
//  - FSM states:
//    IDLE: start -> RUN. Load index with 0 (up) or last_q (down).
//    RUN:  stop -> IDLE. start -> restart: reload settings and first index.
//          tick at final element with loop=0 -> DONE.
//    DONE: lasts one cycle with done=1, then -> IDLE. start in DONE -> RUN.
//  - Setting latch: last_q, dir_q and loop_q are latched on start. Later changes to
//    last_idx, dir or loop have no effect until the next start.
//    last_idx >= MAX_LEN is clamped to MAX_LEN-1.
//  - Latency: start at cycle N -> busy=1, valid=1, index=first at N+1.
//    A tick cycle sets index to the next element one cycle later.
//  - Step rules:
//    up:   idx==last_q ? (loop ? 0 : DONE) : idx+1
//    down: idx==0 ? (loop ? last_q : DONE) : idx-1
//    No tick -> index holds.
//    last_q==0 -> single element; loop repeats it, one-shot ends on the first tick.
//  - valid = busy. In IDLE and DONE, index and digit keep their last values.
//  - Priority in one cycle: rst > stop > start > tick. stop+start -> IDLE.
//    start+tick -> restart only; the tick is ignored.
//  - digit is a combinational read of table[index] (registered index, registered table).
//  - Writes: wr_en stores wr_data at the clock edge.
//    wr_addr >= MAX_LEN is ignored.
//    Writes are allowed in any state; a write to the current index shows on digit
//    the next cycle.
//  - Index arithmetic is IDX_W wide; wrap uses compare only, never natural overflow,
//    so non-power-of-2 MAX_LEN is correct.
//  - rst asserted mid-RUN: immediate return to reset values, table included.
// STRUCTURE
//  - Package digit_seq_pkg holds:
//    state enum {IDLE, RUN, DONE}
//    DIR_UP/DIR_DOWN constants
//    function next_idx(idx, last, dir) returning the wrapped index plus an end flag
//  - Sub-module digit_table: MAX_LEN x DIGIT_W register file. It has async-reset
//    entries, one write port, and one combinational read port.
//  - Top level holds the FSM, the setting latches and the index register.
// TESTING
//  1. Load 9,8,6,6,5,6,2,4,1,8 at 0..9; last_idx=9, up, loop=1, tick every cycle
//     -> digit 9,8,6,6,5,6,2,4,1,8,9,... and index wraps 9->0.
//  2. Same table, down, loop=0, tick every cycle -> digits 8,1,4,...,9.
//     done=1 for exactly one cycle after index 0's tick, then valid=0, busy=0.
//  3. tick every 3rd cycle, last_idx=3 -> index holds two cycles between steps.
//     Change last_idx to 9 mid-run -> still wraps at 3.
//  4. stop and start together in RUN -> IDLE, valid=0.
//     start and tick together -> index=first element, not advanced.
//  5. Write 7 to the current index during RUN -> digit=7 on the next cycle.
//     wr_addr=15 with MAX_LEN=10 -> table unchanged.
//  6. rst asserted asynchronously mid-run, between edges -> index=0, valid=0,
//     busy=0, digit=0 immediately. last_idx=0 with loop=1 -> digit constant, busy stays 1.

Source files
------------

// File: rtl/digit_sequence_player_pkg.sv
// Shared types and step arithmetic for the digit sequence player.
// Latency: none (types, constants and a pure function only).
// Backpressure: none.
package digit_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Fixed working width for the step function; callers zero-extend their
  // index into it. Supports tables of up to 128 entries.
  localparam int IDX_MAX_W = 8;

  typedef struct packed {
    logic                 at_end;  // idx was the final element for this direction
    logic [IDX_MAX_W-1:0] idx;     // wrapped successor (only used when looping)
  } step_t;

  // Successor of idx for the given direction. Wrap is done by comparison with
  // the end points, never by counter overflow, so any table depth works.
  function automatic step_t next_idx(input logic [IDX_MAX_W-1:0] idx,
                                     input logic [IDX_MAX_W-1:0] last,
                                     input logic                 dir);
    step_t r;
    r.at_end = 1'b0;
    r.idx    = idx;
    if (dir == DIR_UP) begin
      if (idx == last) begin
        r.at_end = 1'b1;
        r.idx    = '0;
      end else begin
        r.idx = idx + 1'b1;
      end
    end else begin
      if (idx == '0) begin
        r.at_end = 1'b1;
        r.idx    = last;
      end else begin
        r.idx = idx - 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/digit_sequence_player_if.sv
// Control/status bundle between a host and the digit sequence player.
// Latency: none (wiring only).
// Backpressure: none; tick is a plain advance enable, every write is accepted.
// Host drives: wr_en/wr_addr/wr_data, last_idx/dir/loop, start/stop/tick.
// Player drives: index, digit, valid, busy, done.
interface digit_sequence_player_if #(
  parameter int DIGIT_W = 4,
  parameter int MAX_LEN = 16,
  parameter int IDX_W   = $clog2(MAX_LEN)
);
  logic               wr_en;
  logic [IDX_W-1:0]   wr_addr;
  logic [DIGIT_W-1:0] wr_data;
  logic [IDX_W-1:0]   last_idx;
  logic               dir;
  logic               loop;
  logic               start;
  logic               stop;
  logic               tick;
  logic [IDX_W-1:0]   index;
  logic [DIGIT_W-1:0] digit;
  logic               valid;
  logic               busy;
  logic               done;

  modport master (
    output wr_en, wr_addr, wr_data, last_idx, dir, loop, start, stop, tick,
    input  index, digit, valid, busy, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, last_idx, dir, loop, start, stop, tick,
    output index, digit, valid, busy, done
  );
endinterface

// File: rtl/digit_sequence_player_table.sv
// Digit table: MAX_LEN x DIGIT_W register file, one write port, one comb read.
// Latency: write lands at the clock edge; read is combinational.
// Backpressure: none; out-of-range write addresses are silently dropped.
// Ports: clk, rst (async, active high, clears all entries), wr_en/wr_addr/
//        wr_data write port, rd_addr/rd_data read port.
module digit_table #(
  parameter int DIGIT_W = 4,
  parameter int MAX_LEN = 16,
  parameter int IDX_W   = $clog2(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_addr,
  input  logic [DIGIT_W-1:0] wr_data,
  input  logic [IDX_W-1:0]   rd_addr,
  output logic [DIGIT_W-1:0] rd_data
);

  logic [DIGIT_W-1:0] mem [MAX_LEN];

  // Per-entry address decode: an address past the last entry matches nothing,
  // which drops the write and never indexes outside the array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_LEN; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < MAX_LEN; i++) begin
        if (wr_en && (wr_addr == IDX_W'(i))) mem[i] <= wr_data;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (rd_addr == IDX_W'(i)) rd_data = mem[i];
    end
  end

endmodule

// File: rtl/digit_sequence_player.sv
// Plays a stored digit sequence, one element per tick, up/down, loop or one-shot.
// Latency: start -> first element valid next cycle; tick -> next element next cycle.
// Backpressure: none; tick is an advance enable, a step happens on every tick cycle.
// Ports: clk, rst (async, active high); bus (slave) carries table writes,
//        playback settings/commands and index/digit/valid/busy/done status.
module digit_sequence_player
  import digit_seq_pkg::*;
#(
  parameter int DIGIT_W = 4,
  parameter int MAX_LEN = 16
) (
  input logic                    clk,
  input logic                    rst,
  digit_sequence_player_if.slave bus
);

  localparam int                IDX_W   = $clog2(MAX_LEN);
  localparam logic [IDX_W:0]    LEN_EXT = (IDX_W + 1)'(MAX_LEN);
  localparam logic [IDX_W-1:0]  LAST_OK = IDX_W'(MAX_LEN - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] index_q;
  logic [IDX_W-1:0] last_q;
  logic             dir_q;
  logic             loop_q;
  logic [IDX_W-1:0] last_clamped;
  logic             go;
  logic             advance;
  logic             step_end;
  step_t            nxt;

  // stop outranks start, so a start only takes effect without stop.
  assign go = bus.start & ~bus.stop;

  assign last_clamped = ({1'b0, bus.last_idx} >= LEN_EXT) ? LAST_OK : bus.last_idx;

  // Any successor outside the index width is treated as an end-of-sequence.
  always_comb begin
    nxt      = next_idx(IDX_MAX_W'(index_q), IDX_MAX_W'(last_q), dir_q);
    step_end = nxt.at_end | (|nxt.idx[IDX_MAX_W-1:IDX_W]);
  end

  // A tick moves the index unless it finishes a one-shot run (index holds).
  assign advance = ~bus.stop & ~bus.start & (state_q == RUN) & bus.tick &
                   (~step_end | loop_q);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (bus.stop) begin
      state_d = IDLE;
    end else if (bus.start) begin
      state_d = RUN;
    end else begin
      unique case (state_q)
        IDLE:    state_d = IDLE;
        RUN:     if (bus.tick && step_end && !loop_q) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs
  always_comb begin
    bus.busy  = (state_q == RUN);
    bus.valid = (state_q == RUN);
    bus.done  = (state_q == DONE);
  end

  // Setting latches and index register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      index_q <= '0;
      last_q  <= '0;
      dir_q   <= DIR_UP;
      loop_q  <= 1'b0;
    end else if (go) begin
      last_q  <= last_clamped;
      dir_q   <= bus.dir;
      loop_q  <= bus.loop;
      index_q <= (bus.dir == DIR_DOWN) ? last_clamped : '0;
    end else if (advance) begin
      index_q <= nxt.idx[IDX_W-1:0];
    end
  end

  assign bus.index = index_q;

  digit_table #(
    .DIGIT_W (DIGIT_W),
    .MAX_LEN (MAX_LEN),
    .IDX_W   (IDX_W)
  ) u_table (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (bus.wr_en),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .rd_addr (index_q),
    .rd_data (bus.digit)
  );

endmodule

// File: tb/tb_digit_sequence_player.sv
// Bench for digit_sequence_player: directed scenarios plus random traffic,
// checked every cycle against a sequence-list reference model.
module tb_digit_sequence_player;

  localparam int DW = 4;
  localparam int ML = 10;
  localparam int IW = $clog2(ML);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  digit_sequence_player_if #(.DIGIT_W(DW), .MAX_LEN(ML)) bus ();

  digit_sequence_player #(.DIGIT_W(DW), .MAX_LEN(ML)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: playback is a list of indices built on start, walked
  // by a position counter.
  int m_tab [ML];
  int m_order [$];
  int m_pos;
  int m_idx;
  bit m_play;
  bit m_loop;
  bit m_done;

  int seq [10] = '{9, 8, 6, 6, 5, 6, 2, 4, 1, 8};

  function void model_reset();
    foreach (m_tab[i]) m_tab[i] = 0;
    m_order.delete();
    m_pos  = 0;
    m_idx  = 0;
    m_play = 1'b0;
    m_loop = 1'b0;
    m_done = 1'b0;
  endfunction

  function void model_edge();
    int last;
    m_done = 1'b0;
    if (bus.stop) begin
      m_play = 1'b0;
    end else if (bus.start) begin
      last = (int'(bus.last_idx) > ML - 1) ? ML - 1 : int'(bus.last_idx);
      m_order.delete();
      for (int k = 0; k <= last; k++) m_order.push_back(bus.dir ? last - k : k);
      m_pos  = 0;
      m_idx  = m_order[0];
      m_play = 1'b1;
      m_loop = bus.loop;
    end else if (m_play && bus.tick) begin
      if (m_pos == m_order.size() - 1) begin
        if (m_loop) begin
          m_pos = 0;
          m_idx = m_order[0];
        end else begin
          m_play = 1'b0;
          m_done = 1'b1;
        end
      end else begin
        m_pos++;
        m_idx = m_order[m_pos];
      end
    end
    if (bus.wr_en && int'(bus.wr_addr) < ML) m_tab[int'(bus.wr_addr)] = int'(bus.wr_data);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".index"}, 32'(bus.index), m_idx);
    check({tag, ".digit"}, 32'(bus.digit), m_tab[m_idx]);
    check({tag, ".valid"}, 32'(bus.valid), 32'(m_play));
    check({tag, ".busy"},  32'(bus.busy),  32'(m_play));
    check({tag, ".done"},  32'(bus.done),  32'(m_done));
  endtask

  // Apply the current inputs for one clock edge and compare afterwards.
  task automatic cyc(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.last_idx = '0;
    bus.dir      = 1'b0;
    bus.loop     = 1'b0;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.tick     = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    model_reset();
    #12;
    check_all("reset");
    check("reset.digit0", 32'(bus.digit), 0);
    rst = 1'b0;

    // 1: load table, play up in a loop with tick every cycle
    for (int i = 0; i < 10; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = IW'(i);
      bus.wr_data = DW'(seq[i]);
      cyc("load");
    end
    bus.wr_en    = 1'b0;
    bus.last_idx = IW'(9);
    bus.dir      = 1'b0;
    bus.loop     = 1'b1;
    bus.start    = 1'b1;
    bus.tick     = 1'b1;
    cyc("t1.start");
    check("t1.first", 32'(bus.digit), 9);
    bus.start = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      cyc("t1.run");
      check("t1.seq", 32'(bus.digit), seq[k % 10]);
    end

    // 2: down, one-shot
    bus.dir   = 1'b1;
    bus.loop  = 1'b0;
    bus.start = 1'b1;
    cyc("t2.start");
    bus.start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      cyc("t2.run");
      if (k == 10) check("t2.donepulse", 32'(bus.done), 1);
      if (k == 11) begin
        check("t2.doneclr", 32'(bus.done), 0);
        check("t2.busyclr", 32'(bus.busy), 0);
      end
    end

    // 3: sparse ticks, settings change mid-run has no effect
    bus.last_idx = IW'(3);
    bus.dir      = 1'b0;
    bus.loop     = 1'b1;
    bus.start    = 1'b1;
    bus.tick     = 1'b0;
    cyc("t3.start");
    bus.start = 1'b0;
    for (int k = 0; k < 18; k++) begin
      bus.tick = (k % 3 == 2);
      if (k == 5) begin
        bus.last_idx = IW'(9);
        bus.dir      = 1'b1;
      end
      cyc("t3.run");
    end

    // 4: stop+start -> idle; start+tick -> first element only
    bus.stop  = 1'b1;
    bus.start = 1'b1;
    cyc("t4.stopstart");
    check("t4.valid0", 32'(bus.valid), 0);
    bus.stop     = 1'b0;
    bus.last_idx = IW'(5);
    bus.dir      = 1'b0;
    bus.tick     = 1'b1;
    cyc("t4.starttick");
    check("t4.first", 32'(bus.index), 0);
    bus.start = 1'b0;

    // 5: write to the current index while running; out-of-range write
    cyc("t5.step");
    cyc("t5.step");
    bus.tick    = 1'b0;
    bus.wr_en   = 1'b1;
    bus.wr_addr = IW'(m_idx);
    bus.wr_data = DW'(7);
    cyc("t5.wr");
    check("t5.digit7", 32'(bus.digit), 7);
    bus.wr_addr = IW'(15);
    bus.wr_data = DW'(3);
    cyc("t5.oob");
    bus.wr_en    = 1'b0;
    bus.last_idx = IW'(9);
    bus.start    = 1'b1;
    bus.tick     = 1'b1;
    cyc("t5.restart");
    bus.start = 1'b0;
    repeat (11) cyc("t5.scan");

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      bus.start    = ($urandom % 12 == 0);
      bus.stop     = ($urandom % 24 == 0);
      bus.tick     = $urandom % 2;
      bus.wr_en    = ($urandom % 4 == 0);
      bus.wr_addr  = IW'($urandom_range(0, 15));
      bus.wr_data  = DW'($urandom_range(0, 15));
      bus.last_idx = IW'($urandom_range(0, 15));
      bus.dir      = $urandom % 2;
      bus.loop     = $urandom % 2;
      cyc("rand");
    end

    // 6: async reset between edges mid-run
    idle_inputs();
    bus.last_idx = IW'(9);
    bus.loop     = 1'b1;
    bus.start    = 1'b1;
    bus.tick     = 1'b1;
    cyc("t6.start");
    bus.start = 1'b0;
    repeat (3) cyc("t6.run");
    #3 rst = 1'b1;
    #1;
    model_reset();
    check_all("t6.arst");
    check("t6.arst.digit0", 32'(bus.digit), 0);
    #1 rst = 1'b0;
    bus.tick = 1'b0;
    cyc("t6.post");

    // Single-element sequence, looping then one-shot
    bus.wr_en   = 1'b1;
    bus.wr_addr = '0;
    bus.wr_data = DW'(5);
    cyc("t6.wr0");
    bus.wr_en    = 1'b0;
    bus.last_idx = '0;
    bus.loop     = 1'b1;
    bus.start    = 1'b1;
    cyc("t6.single");
    bus.start = 1'b0;
    bus.tick  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc("t6.loop1");
      check("t6.busy1", 32'(bus.busy), 1);
      check("t6.const", 32'(bus.digit), 5);
    end
    bus.loop  = 1'b0;
    bus.start = 1'b1;
    cyc("t6.oneshot");
    bus.start = 1'b0;
    cyc("t6.oneshot.end");
    check("t6.oneshot.done", 32'(bus.done), 1);
    bus.tick = 1'b0;
    cyc("t6.idle");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
